// File: rtl/m_seq_correlator_if.sv
// ---------------------------------------------------------------------------
// m_seq_correlator_if
// Chip stream and detection result bundle for the M-sequence correlator.
//   chip_in      received chip
//   chip_valid   chip_in is valid this cycle
//   frame_start  current chip is r[0] of a new frame
//   in_ready     correlator accepts chips this cycle
//   shift_out    detected code shift (0..62)
//   peak         agreement count at shift_out (0..63)
//   det_valid    one-cycle pulse, result fields updated
//   locked       peak reached the lock threshold at last detection
// master: chip source / result consumer.  slave: the correlator.
// ---------------------------------------------------------------------------
interface m_seq_correlator_if;
    logic       chip_in;
    logic       chip_valid;
    logic       frame_start;
    logic       in_ready;
    logic [5:0] shift_out;
    logic [6:0] peak;
    logic       det_valid;
    logic       locked;

    modport master (
        output chip_in, chip_valid, frame_start,
        input  in_ready, shift_out, peak, det_valid, locked
    );

    modport slave (
        input  chip_in, chip_valid, frame_start,
        output in_ready, shift_out, peak, det_valid, locked
    );
endinterface

// File: rtl/m_seq_correlator.sv
// ---------------------------------------------------------------------------
// m_seq_correlator
// Buffers one 63-chip received frame and correlates it serially against all
// cyclic shifts of a locally generated reference M-sequence, one candidate
// shift per cycle. Reports the best shift, its agreement count and a lock flag.
//   clkin   clock
//   rstn    synchronous active-low reset
//   bus     m_seq_correlator_if.slave (chip stream in, detection result out)
//
// state     | meaning
// S_INIT    | build reference s[0..62] from the LFSR, one chip per cycle
// S_COLLECT | accept chips into the frame buffer
// S_SEARCH  | evaluate agreement for shift j = 0..62, one per cycle
// S_REPORT  | one-cycle result pulse; chips are accepted again
// ---------------------------------------------------------------------------
module m_seq_correlator #(
    parameter logic [5:0] POLYNOME = 6'b100111,
    parameter logic [5:0] PHASE    = 6'b101010,
    parameter logic [5:0] N        = 6'd63,
    parameter logic [3:0] LENGHT   = 4'd6,
    parameter logic [6:0] THRESH   = 7'd56
) (
    input  logic                 clkin,
    input  logic                 rstn,
    m_seq_correlator_if.slave    bus
);

    localparam int NI = int'(N);
    localparam int LI = int'(LENGHT);
    localparam logic [5:0] LAST = 6'(NI - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_COLLECT,
        S_SEARCH,
        S_REPORT
    } state_t;

    state_t          state, state_nxt;
    logic [LI-1:0]   lfsr;
    logic [5:0]      idx;        // INIT fill index, then SEARCH candidate j
    logic [5:0]      cnt;        // chips collected in the current frame
    logic [NI-1:0]   ref_seq;
    logic [NI-1:0]   wref;       // reference rotated by the current j
    logic [NI-1:0]   frame;
    logic [5:0]      best_j;
    logic [6:0]      best_a;
    logic [5:0]      shift_r;
    logic [6:0]      peak_r;
    logic            det_r;
    logic            locked_r;

    logic            in_ready_i;
    logic            accept;
    logic            last_chip;
    logic            fb;
    logic [6:0]      agree;
    logic            better;
    logic [6:0]      cand_a;
    logic [5:0]      cand_j;

    assign fb        = ^(lfsr & POLYNOME[LI-1:0]);
    assign accept    = bus.chip_valid && in_ready_i;
    assign last_chip = accept && !bus.frame_start && (cnt == LAST);

    // Mismatches are counted by XOR; agreement is their complement to N.
    assign agree  = 7'(NI) - 7'($countones(frame ^ wref));
    // j = 0 seeds the search; afterwards only a strictly better shift wins,
    // so ties stay with the lowest j.
    assign better = (idx == 6'd0) || (agree > best_a);
    assign cand_a = better ? agree : best_a;
    assign cand_j = better ? idx   : best_j;

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready_i = 1'b0;
        case (state)
            S_INIT: begin
                if (idx == LAST) begin
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT, S_REPORT: begin
                in_ready_i = 1'b1;
                state_nxt  = last_chip ? S_SEARCH : S_COLLECT;
            end
            S_SEARCH: begin
                if (idx == LAST) begin
                    state_nxt = S_REPORT;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            lfsr     <= PHASE[LI-1:0];
            idx      <= '0;
            cnt      <= '0;
            ref_seq  <= '0;
            wref     <= '0;
            frame    <= '0;
            best_j   <= '0;
            best_a   <= '0;
            shift_r  <= '0;
            peak_r   <= '0;
            det_r    <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            det_r <= 1'b0;
            case (state)
                S_INIT: begin
                    ref_seq[idx] <= fb;
                    lfsr         <= {fb, lfsr[LI-1:1]};
                    idx          <= (idx == LAST) ? 6'd0 : idx + 6'd1;
                end
                S_COLLECT, S_REPORT: begin
                    if (accept) begin
                        if (bus.frame_start) begin
                            frame[0] <= bus.chip_in;
                            cnt      <= 6'd1;
                        end else begin
                            frame[cnt] <= bus.chip_in;
                            if (cnt == LAST) begin
                                cnt  <= 6'd0;
                                wref <= ref_seq;
                            end else begin
                                cnt <= cnt + 6'd1;
                            end
                        end
                    end else if (bus.frame_start) begin
                        cnt <= 6'd0;
                    end
                end
                S_SEARCH: begin
                    best_a <= cand_a;
                    best_j <= cand_j;
                    // wref[t] tracks s[(t+j) mod N]; advancing j pulls every bit down by one.
                    wref   <= {wref[0], wref[NI-1:1]};
                    if (idx == LAST) begin
                        idx      <= 6'd0;
                        shift_r  <= cand_j;
                        peak_r   <= cand_a;
                        locked_r <= (cand_a >= THRESH);
                        det_r    <= 1'b1;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_i;
    assign bus.shift_out = shift_r;
    assign bus.peak      = peak_r;
    assign bus.det_valid = det_r;
    assign bus.locked    = locked_r;

endmodule
